// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-fetch port, the data port, the memory port and the
// status outputs of mem_arbiter.
//   IF_*       : fetch request/grant, address, returned word, valid pulse
//   D_*        : data request/grant, address, store data, byte enables,
//                returned word, valid pulse
//   Mem_*      : registered memory request/address/data/strobes, ack, rdata
//   Core_Stall : core must wait; Bus_Err : timeout pulse
// Modports:
//   slave  - the arbiter itself
//   master - the environment (fetch unit, load/store unit, memory)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        IF_Gnt;
    logic [31:0] IF_Rdata;
    logic        IF_Valid;

    logic        D_Req;
    logic [31:0] D_Addr;
    logic [31:0] D_Wdata;
    logic [3:0]  D_Wstrb;
    logic        D_Gnt;
    logic [31:0] D_Rdata;
    logic        D_Valid;

    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [3:0]  Mem_Wstrb;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;

    logic        Core_Stall;
    logic        Bus_Err;

    modport slave (
        input  IF_Req, IF_Addr,
        input  D_Req, D_Addr, D_Wdata, D_Wstrb,
        input  Mem_Ack, Mem_Rdata,
        output IF_Gnt, IF_Rdata, IF_Valid,
        output D_Gnt, D_Rdata, D_Valid,
        output Mem_Req, Mem_Addr, Mem_Wdata, Mem_Wstrb,
        output Core_Stall, Bus_Err
    );

    modport master (
        output IF_Req, IF_Addr,
        output D_Req, D_Addr, D_Wdata, D_Wstrb,
        output Mem_Ack, Mem_Rdata,
        input  IF_Gnt, IF_Rdata, IF_Valid,
        input  D_Gnt, D_Rdata, D_Valid,
        input  Mem_Req, Mem_Addr, Mem_Wdata, Mem_Wstrb,
        input  Core_Stall, Bus_Err
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. At most one access is outstanding. Ties in IDLE are resolved
// round-robin; an access without Mem_Ack for TIMEOUT_CYC cycles is aborted
// with a Bus_Err pulse and zero read data.
// Ports:
//   Clk_Core   - core clock, all state on rising edge
//   Rst_Core_N - synchronous active-low reset
//   bus        - mem_arbiter_if.slave (fetch, data, memory, status signals)
// Parameters:
//   TIMEOUT_CYC - cycles waited for Mem_Ack before abort (2..255)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 1: data was served last
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_gnt, d_gnt;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so they are gated by reset here;
                // Mem_Ack is simply not looked at in this state.
                if (Rst_Core_N) begin
                    if (bus.IF_Req && (!bus.D_Req || last_gnt_q)) begin
                        if_gnt = 1'b1;
                    end else if (bus.D_Req) begin
                        d_gnt = 1'b1;
                    end
                end
                if (if_gnt) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = bus.IF_Addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    wait_cnt_d  = '0;
                end else if (d_gnt) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = bus.D_Addr;
                    mem_wdata_d = bus.D_Wdata;
                    mem_wstrb_d = bus.D_Wstrb;
                    wait_cnt_d  = '0;
                end
            end

            IF_BUSY, D_BUSY: begin
                // Ack wins over a coinciding timeout.
                if (bus.Mem_Ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    last_gnt_d = (state_q == D_BUSY);
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.Mem_Rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = (mem_wstrb_q == 4'b0000) ? bus.Mem_Rdata : 32'h0;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    last_gnt_d = (state_q == D_BUSY);
                    bus_err_d  = 1'b1;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = 32'h0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = 32'h0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.IF_Gnt     = if_gnt;
    assign bus.D_Gnt      = d_gnt;
    assign bus.IF_Valid   = if_valid_q;
    assign bus.D_Valid    = d_valid_q;
    assign bus.IF_Rdata   = if_rdata_q;
    assign bus.D_Rdata    = d_rdata_q;
    assign bus.Mem_Req    = mem_req_q;
    assign bus.Mem_Addr   = mem_addr_q;
    assign bus.Mem_Wdata  = mem_wdata_q;
    assign bus.Mem_Wstrb  = mem_wstrb_q;
    assign bus.Bus_Err    = bus_err_q;
    // In IDLE this reduces to "a request is pending"; otherwise always high.
    assign bus.Core_Stall = (state_q != IDLE) || bus.IF_Req || bus.D_Req;

endmodule
